// File: rtl/sched_pkg.sv
// Shared decode constants, instruction classes and class decode for the issue scheduler.
package sched_pkg;

  localparam logic [2:0] UNIT_ADVINT = 3'd4;
  localparam logic [2:0] UNIT_STORE  = 3'd6;
  localparam logic [2:0] UNIT_BRANCH = 3'd7;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_ADVINT,
    CLS_MEM,
    CLS_BRANCH,
    CLS_ILL
  } cls_e;

  // Map the decode type bit and unit field onto an execution class.
  function automatic cls_e decode_cls(input logic typ, input logic [2:0] unit);
    cls_e c;
    if (!unit[2])                c = CLS_ALU;
    else if (unit == UNIT_BRANCH) c = CLS_BRANCH;
    else if (typ)                 c = CLS_MEM;
    else if (unit == UNIT_ADVINT) c = CLS_ADVINT;
    else                          c = CLS_ILL;
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Picks one requester out of N, either round-robin from the last grant or lowest index first.
// Ports: clk/rst, req (per-requester), advance (commit the pick), grant_c (one-hot),
//        idx_c (binary pick), any_c (some requester present).
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter bit          RR = 1'b1,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    grant_c = '0;
    idx_c   = ptr_q;
    any_c   = 1'b0;
    cand    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (RR) cand = IW'((int'(ptr_q) + 1 + i) % int'(N));
      else    cand = IW'(i);
      if (!any_c && req[cand]) begin
        any_c = 1'b1;
        idx_c = cand;
      end
    end
    if (any_c) grant_c[idx_c] = 1'b1;
    ptr_d = (advance && any_c) ? idx_c : ptr_q;
  end

  // Pointer resets to the last index so index 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/issue_sched_sb.sv
// In-order issue scheduler with register scoreboard: accepts one decoded op per cycle and
// issues it to a free ALU (round-robin or fixed priority), ADVINT, MEM or BRANCH unit.
// Ports: in_* decode handshake/fields, flush, wb_valid/wb_rn completion ports, per-unit busy
//        inputs, per-unit one-cycle *_en issue pulses, rd_out/rd2_out last destinations,
//        illegal drop pulse, saturating stall_cnt.
module issue_sched_sb
  import sched_pkg::*;
#(
  parameter int unsigned NUM_ALU = 2,
  parameter int unsigned REG_AW  = 6,
  parameter int unsigned NUM_WB  = 2,
  parameter int unsigned RR_ALU  = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_type,
  input  logic [2:0]               in_unit,
  input  logic [REG_AW-1:0]        in_rs1,
  input  logic [REG_AW-1:0]        in_rs2,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic [REG_AW-1:0]        in_rd2,
  input  logic                     flush,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*REG_AW-1:0] wb_rn,
  input  logic [NUM_ALU-1:0]       alu_busy,
  input  logic                     advint_busy,
  input  logic                     mem_busy,
  input  logic                     branch_busy,
  output logic [NUM_ALU-1:0]       alu_en,
  output logic                     advint_en,
  output logic                     mem_en,
  output logic                     branch_en,
  output logic [REG_AW-1:0]        rd_out,
  output logic [REG_AW-1:0]        rd2_out,
  output logic                     illegal,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned NREG = 1 << REG_AW;
  localparam int unsigned AIW  = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  cls_e               cls;
  logic [NREG-1:0]    busy_q, busy_d, clr_mask, set_mask, pend;
  logic [NUM_ALU-1:0] alu_grant;
  logic [AIW-1:0]     alu_idx;
  logic               alu_any, hazard, unit_free, issue;

  logic [NUM_ALU-1:0] alu_en_q, alu_en_d;
  logic               advint_en_q, advint_en_d, mem_en_q, mem_en_d, branch_en_q, branch_en_d;
  logic               illegal_q, illegal_d;
  logic [REG_AW-1:0]  rd_q, rd_d, rd2_q, rd2_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  assign cls = decode_cls(in_type, in_unit);

  rr_arbiter #(.N(NUM_ALU), .RR(RR_ALU != 0)) u_alu_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (~alu_busy),
    .advance (issue && (cls == CLS_ALU)),
    .grant_c (alu_grant),
    .idx_c   (alu_idx),
    .any_c   (alu_any)
  );

  // Handshake, hazard check with same-cycle writeback bypass, and next-state for all flops.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < int'(NUM_WB); i++) begin
      if (wb_valid[i]) clr_mask[wb_rn[i*REG_AW +: REG_AW]] = 1'b1;
    end
    // busy_q[0] is held at 0, so r0 never blocks.
    pend   = busy_q & ~clr_mask;
    hazard = pend[in_rs1] | pend[in_rs2] | pend[in_rd] |
             ((cls == CLS_ADVINT) & pend[in_rd2]);

    unit_free = 1'b1;
    case (cls)
      CLS_ALU:    unit_free = alu_any;
      CLS_ADVINT: unit_free = ~advint_busy;
      CLS_MEM:    unit_free = ~mem_busy;
      default:    unit_free = 1'b1;
    endcase

    in_ready = in_valid & ~flush & ~branch_busy &
               ((cls == CLS_ILL) | (~hazard & unit_free));
    issue    = in_ready & (cls != CLS_ILL);

    alu_en_d    = (issue && cls == CLS_ALU) ? alu_grant : '0;
    advint_en_d = issue && (cls == CLS_ADVINT);
    mem_en_d    = issue && (cls == CLS_MEM);
    branch_en_d = issue && (cls == CLS_BRANCH);
    illegal_d   = in_ready && (cls == CLS_ILL);
    rd_d        = issue ? in_rd : rd_q;
    rd2_d       = (issue && cls == CLS_ADVINT) ? in_rd2 : rd2_q;

    // Stores and branches name no destination to track.
    set_mask = '0;
    if (issue) begin
      if ((cls == CLS_ALU) || (cls == CLS_ADVINT) ||
          ((cls == CLS_MEM) && (in_unit != UNIT_STORE)))
        set_mask[in_rd] = 1'b1;
      if (cls == CLS_ADVINT) set_mask[in_rd2] = 1'b1;
    end
    set_mask[0] = 1'b0;
    // Clears apply first, so a same-register set wins.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      alu_en_q    <= '0;
      advint_en_q <= 1'b0;
      mem_en_q    <= 1'b0;
      branch_en_q <= 1'b0;
      illegal_q   <= 1'b0;
      rd_q        <= '0;
      rd2_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      alu_en_q    <= alu_en_d;
      advint_en_q <= advint_en_d;
      mem_en_q    <= mem_en_d;
      branch_en_q <= branch_en_d;
      illegal_q   <= illegal_d;
      rd_q        <= rd_d;
      rd2_q       <= rd2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign alu_en    = alu_en_q;
  assign advint_en = advint_en_q;
  assign mem_en    = mem_en_q;
  assign branch_en = branch_en_q;
  assign illegal   = illegal_q;
  assign rd_out    = rd_q;
  assign rd2_out   = rd2_q;
  assign stall_cnt = stall_cnt_q;

  logic unused_ok;
  assign unused_ok = ^alu_idx;

endmodule

// File: tb/tb_issue_sched_sb.sv
// Scoreboard bench for issue_sched_sb: stimulus pushes expected issue pulses, a negedge
// monitor pops and compares whenever any issue/illegal pulse appears.
module tb_issue_sched_sb;

  localparam int unsigned NA = 2;
  localparam int unsigned AW = 6;
  localparam int unsigned NW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready, in_type = 1'b0, flush = 1'b0;
  logic [2:0]    in_unit = '0;
  logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_rd2 = '0;
  logic [NW-1:0] wb_valid = '0;
  logic [NW*AW-1:0] wb_rn = '0;
  logic [NA-1:0] alu_busy = '0, alu_en;
  logic          advint_busy = 1'b0, mem_busy = 1'b0, branch_busy = 1'b0;
  logic          advint_en, mem_en, branch_en, illegal;
  logic [AW-1:0] rd_out, rd2_out;
  logic [31:0]   stall_cnt;

  // Small-counter instance used only for saturation.
  logic          s_valid = 1'b0, s_bb = 1'b0, s_ready, s_adv, s_mem, s_br, s_ill;
  logic [NA-1:0] s_alu_en;
  logic [AW-1:0] s_rd, s_rd2;
  logic [3:0]    s_cnt;
  logic [2:0]    zero3 = '0;
  logic [AW-1:0] zero_r = '0;
  logic [NW-1:0] zero_wv = '0;
  logic [NW*AW-1:0] zero_wr = '0;
  logic [NA-1:0] zero_ab = '0;
  logic          zero1 = 1'b0;

  issue_sched_sb #(.NUM_ALU(NA), .REG_AW(AW), .NUM_WB(NW), .RR_ALU(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_unit(in_unit), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd2(in_rd2),
    .flush(flush), .wb_valid(wb_valid), .wb_rn(wb_rn), .alu_busy(alu_busy),
    .advint_busy(advint_busy), .mem_busy(mem_busy), .branch_busy(branch_busy),
    .alu_en(alu_en), .advint_en(advint_en), .mem_en(mem_en), .branch_en(branch_en),
    .rd_out(rd_out), .rd2_out(rd2_out), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  issue_sched_sb #(.NUM_ALU(NA), .REG_AW(AW), .NUM_WB(NW), .RR_ALU(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready), .in_type(zero1),
    .in_unit(zero3), .in_rs1(zero_r), .in_rs2(zero_r), .in_rd(zero_r), .in_rd2(zero_r),
    .flush(zero1), .wb_valid(zero_wv), .wb_rn(zero_wr), .alu_busy(zero_ab),
    .advint_busy(zero1), .mem_busy(zero1), .branch_busy(s_bb),
    .alu_en(s_alu_en), .advint_en(s_adv), .mem_en(s_mem), .branch_en(s_br),
    .rd_out(s_rd), .rd2_out(s_rd2), .illegal(s_ill), .stall_cnt(s_cnt)
  );

  typedef struct packed {
    logic [1:0] alu;
    logic       adv;
    logic       mem;
    logic       br;
    logic       ill;
    logic [5:0] rd;
    logic [5:0] rd2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_stall = 0;

  function automatic exp_t mk(input logic [1:0] alu, input logic adv, input logic mem,
                              input logic br, input logic ill,
                              input logic [5:0] rd, input logic [5:0] rd2);
    exp_t e;
    e = {alu, adv, mem, br, ill, rd, rd2};
    return e;
  endfunction

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every issue/illegal pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    act = {alu_en, advint_en, mem_en, branch_en, illegal, rd_out, rd2_out};
    if ((|alu_en) || advint_en || mem_en || branch_en || illegal) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL issue: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic drive(input logic typ, input logic [2:0] unit, input logic [5:0] rs1,
                       input logic [5:0] rs2, input logic [5:0] rd, input logic [5:0] rd2);
    in_valid = 1'b1; in_type = typ; in_unit = unit;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd2 = rd2;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_valid = '0; wb_rn = '0;
  endtask

  // One cycle: check counter and handshake at negedge, optionally expect an issue.
  task automatic step(input logic exp_rdy, input logic push, input exp_t e, input string nm);
    @(negedge clk);
    chk(stall_cnt, 32'(exp_stall), "stall_cnt");
    chk(32'(in_ready), 32'(exp_rdy), nm);
    if (in_valid && !exp_rdy) exp_stall++;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  exp_t nx;

  initial begin
    nx = '0;
    // Reset state
    @(negedge clk);
    chk(32'(alu_en), 0, "rst_alu_en");
    chk(32'({advint_en, mem_en, branch_en, illegal}), 0, "rst_pulses");
    chk(32'(rd_out), 0, "rst_rd_out");
    chk(32'(rd2_out), 0, "rst_rd2_out");
    chk(stall_cnt, 0, "rst_stall_cnt");
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: RAW stall, released by same-cycle writeback
    drive(0, 3'd0, 6'd1, 6'd2, 6'd3, 6'd0); step(1, 1, mk(2'b01,0,0,0,0,6'd3,6'd0), "t1_first");
    drive(0, 3'd0, 6'd3, 6'd0, 6'd4, 6'd0);
    for (int i = 0; i < 3; i++) step(0, 0, nx, "t1_raw_stall");
    wb_valid = 2'b01; wb_rn = {6'd0, 6'd3};
    step(1, 1, mk(2'b10,0,0,0,0,6'd4,6'd0), "t1_bypass");
    idle();

    // 2: round-robin over two ALUs
    for (int i = 0; i < 4; i++) begin
      drive(0, 3'd1, 6'd0, 6'd0, 6'(10 + i), 6'd0);
      step(1, 1, mk((i % 2 == 0) ? 2'b01 : 2'b10, 0,0,0,0, 6'(10 + i), 6'd0), "t2_rr");
    end
    idle();

    // 3: ADVINT double destination, WAW stall on rd2, set beats same-cycle clear
    drive(0, 3'd4, 6'd0, 6'd0, 6'd5, 6'd6); step(1, 1, mk(2'b00,1,0,0,0,6'd5,6'd6), "t3_adv");
    drive(0, 3'd2, 6'd0, 6'd0, 6'd6, 6'd0);
    step(0, 0, nx, "t3_waw_stall"); step(0, 0, nx, "t3_waw_stall");
    wb_valid = 2'b10; wb_rn = {6'd6, 6'd0};
    step(1, 1, mk(2'b01,0,0,0,0,6'd6,6'd6), "t3_waw_release");
    idle();
    drive(0, 3'd0, 6'd6, 6'd0, 6'd14, 6'd0); step(0, 0, nx, "t3_set_wins");
    idle(); step(0, 0, nx, "t3_idle");

    // 4: store marks nothing, r0 never stalls, illegal op dropped, load marks rd
    drive(1, 3'd6, 6'd0, 6'd0, 6'd7, 6'd0); step(1, 1, mk(2'b00,0,1,0,0,6'd7,6'd6), "t4_store");
    drive(0, 3'd0, 6'd7, 6'd0, 6'd8, 6'd0); step(1, 1, mk(2'b10,0,0,0,0,6'd8,6'd6), "t4_after_store");
    drive(0, 3'd0, 6'd0, 6'd0, 6'd0, 6'd0); step(1, 1, mk(2'b01,0,0,0,0,6'd0,6'd6), "t4_r0_a");
    drive(0, 3'd3, 6'd0, 6'd0, 6'd0, 6'd0); step(1, 1, mk(2'b10,0,0,0,0,6'd0,6'd6), "t4_r0_b");
    drive(0, 3'd5, 6'd4, 6'd0, 6'd9, 6'd0); step(1, 1, mk(2'b00,0,0,0,1,6'd0,6'd6), "t4_illegal");
    drive(1, 3'd5, 6'd0, 6'd0, 6'd20, 6'd0); step(1, 1, mk(2'b00,0,1,0,0,6'd20,6'd6), "t4_load");
    drive(0, 3'd0, 6'd20, 6'd0, 6'd15, 6'd0); step(0, 0, nx, "t4_load_raw");
    alu_busy = 2'b11;
    drive(0, 3'd0, 6'd0, 6'd0, 6'd21, 6'd0); step(0, 0, nx, "t4_alus_busy");
    alu_busy = 2'b01; step(1, 1, mk(2'b10,0,0,0,0,6'd21,6'd6), "t4_alu1_only");
    alu_busy = 2'b00; idle();

    // 5: branch_busy stalls ten cycles, flush blocks, branch issue
    branch_busy = 1'b1;
    drive(0, 3'd0, 6'd0, 6'd0, 6'd23, 6'd0);
    for (int i = 0; i < 10; i++) step(0, 0, nx, "t5_branch_busy");
    branch_busy = 1'b0; flush = 1'b1; step(0, 0, nx, "t5_flush");
    flush = 1'b0; step(1, 1, mk(2'b01,0,0,0,0,6'd23,6'd6), "t5_after_flush");
    drive(0, 3'd7, 6'd0, 6'd0, 6'd22, 6'd0); step(1, 1, mk(2'b00,0,0,1,0,6'd22,6'd6), "t5_branch");
    drive(0, 3'd0, 6'd22, 6'd0, 6'd24, 6'd0); step(1, 1, mk(2'b10,0,0,0,0,6'd24,6'd6), "t5_after_branch");
    idle(); step(0, 0, nx, "t5_idle");
    chk(stall_cnt, 32'(exp_stall), "t5_stall_total");

    // Saturation on the 4-bit counter instance
    s_valid = 1'b1; s_bb = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 14) chk(32'(s_cnt), 14, "sat_14");
      if (k == 15) chk(32'(s_cnt), 15, "sat_15");
      if (k == 20) chk(32'(s_cnt), 15, "sat_hold");
    end
    s_valid = 1'b0; s_bb = 1'b0;

    // 6: reset during an accepted cycle drops the pulse and clears the scoreboard
    drive(0, 3'd0, 6'd0, 6'd0, 6'd30, 6'd0);
    @(negedge clk);
    chk(32'(in_ready), 1, "t6_ready_pre_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk(32'(alu_en), 0, "t6_rst_alu_en");
    chk(32'(rd_out), 0, "t6_rst_rd_out");
    chk(32'(rd2_out), 0, "t6_rst_rd2_out");
    chk(stall_cnt, 0, "t6_rst_stall");
    exp_stall = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 3'd0, 6'd4, 6'd5, 6'd6, 6'd0); step(1, 1, mk(2'b01,0,0,0,0,6'd6,6'd0), "t6_post_rst");
    idle();
    for (int i = 0; i < 3; i++) step(0, 0, nx, "t6_idle");

    chk(32'(exp_q.size()), 0, "pending_expected");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
